// File: rtl/stage_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stage_sequencer_if
//   Bundles the memory handshake, error input and commit/status outputs of
//   the stage sequencer. The master modport is the sequencer side.
//   Revision: 1.0
// ---------------------------------------------------------------------------
interface stage_sequencer_if #(
  parameter int INSTRET_WIDTH = 32
);
  logic                     run_enable;
  logic                     mem_ready;
  logic                     ex_needs_mem;
  logic                     error;
  logic [1:0]               current_pipeline_stage;
  logic                     fetch_req;
  logic                     ir_load;
  logic                     ex_mem_req;
  logic                     pc_write;
  logic                     reg_write_en;
  logic                     halted;
  logic                     timeout_error;
  logic [INSTRET_WIDTH-1:0] instret;

  modport master (
    input  run_enable, mem_ready, ex_needs_mem, error,
    output current_pipeline_stage, fetch_req, ir_load, ex_mem_req,
           pc_write, reg_write_en, halted, timeout_error, instret
  );

  modport slave (
    output run_enable, mem_ready, ex_needs_mem, error,
    input  current_pipeline_stage, fetch_req, ir_load, ex_mem_req,
           pc_write, reg_write_en, halted, timeout_error, instret
  );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stage_sequencer
//   Multi-cycle control FSM: fetch / decode / operand / execute / writeback,
//   memory handshaking with a request timeout, commit gating and a permanent
//   halt on error or timeout.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module stage_sequencer #(
  parameter int INSTRET_WIDTH = 32,
  parameter int MEM_TIMEOUT   = 255
) (
  input  wire logic           clk,
  input  wire logic           reset,
  stage_sequencer_if.master   bus
);

  // The counter only ever holds 0..MEM_TIMEOUT-1; the limit is detected on
  // the waiting cycle that would take it to MEM_TIMEOUT.
  localparam int c_TCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_WB      = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_OPERAND = 3'd3,
    S_EXECUTE = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_commit_pending;
  logic [c_TCNT_W-1:0]      r_tcnt;
  logic                     r_timeout_error;
  logic [INSTRET_WIDTH-1:0] r_instret;

  logic [1:0] w_stage;
  logic       w_fetch_req;
  logic       w_ir_load;
  logic       w_ex_mem_req;
  logic       w_commit;
  logic       w_halted;
  logic       w_waiting;
  logic       w_timeout;

  // Next-state and per-state outputs; error and timeout override everything.
  always_comb begin
    w_next       = r_state;
    w_stage      = 2'd0;
    w_fetch_req  = 1'b0;
    w_ir_load    = 1'b0;
    w_ex_mem_req = 1'b0;
    w_commit     = 1'b0;
    w_halted     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_fetch_req = bus.run_enable;
        w_ir_load   = bus.run_enable & bus.mem_ready;
        if (w_ir_load) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_stage = 2'd1;
        w_next  = S_OPERAND;
      end
      S_OPERAND: begin
        w_stage = 2'd2;
        w_next  = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_stage = 2'd3;
        if (!bus.ex_needs_mem) begin
          w_next = S_WB;
        end else begin
          w_ex_mem_req = 1'b1;
          if (bus.mem_ready) w_next = S_WB;
        end
      end
      S_WB: begin
        // The error seen here is the registered execute-fault result.
        w_commit = r_commit_pending & ~bus.error;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next = S_HALT;
      end
    endcase
    // A mem_ready on the limit cycle completes the request instead.
    w_waiting = (w_fetch_req | w_ex_mem_req) & ~bus.mem_ready;
    w_timeout = w_waiting & (r_tcnt == c_TCNT_LAST);
    if (w_timeout || bus.error) w_next = S_HALT;
  end

  // State register and commit-pending flag (set on entry to writeback).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_FETCH;
      r_commit_pending <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_commit_pending <= (w_next == S_WB);
    end
  end

  // Request wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt          <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      r_tcnt          <= (w_waiting && !w_timeout) ? r_tcnt + c_TCNT_W'(1) : '0;
      r_timeout_error <= r_timeout_error | w_timeout;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_commit) begin
      r_instret <= r_instret + INSTRET_WIDTH'(1);
    end
  end

  // Requests and strobes are masked while reset is held so nothing is
  // issued before the first clean fetch.
  assign bus.current_pipeline_stage = w_stage;
  assign bus.fetch_req              = w_fetch_req  & ~reset;
  assign bus.ir_load                = w_ir_load    & ~reset;
  assign bus.ex_mem_req             = w_ex_mem_req & ~reset;
  assign bus.pc_write               = w_commit     & ~reset;
  assign bus.reg_write_en           = w_commit     & ~reset;
  assign bus.halted                 = w_halted;
  assign bus.timeout_error          = r_timeout_error;
  assign bus.instret                = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stage_sequencer
//   Self-checking bench: vector table, directed corner sequences and a
//   randomized run against an instruction-phase reference model.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module tb_stage_sequencer;

  localparam int C_TO = 4;

  logic clk;
  logic reset;

  stage_sequencer_if #(.INSTRET_WIDTH(32)) bus ();

  stage_sequencer #(
    .INSTRET_WIDTH (32),
    .MEM_TIMEOUT   (C_TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction phase 0..4 (fetch..writeback), wait length.
  int          m_phase;
  int          m_wait;
  bit          m_halt;
  bit          m_to;
  logic [31:0] m_instret;
  logic [1:0]  e_stg;
  bit          e_fr, e_irl, e_emr, e_cm, e_hlt;

  function automatic void model_reset();
    m_phase = 0; m_wait = 0; m_halt = 0; m_to = 0; m_instret = '0;
  endfunction

  function automatic void model_outputs();
    e_stg = 2'd0; e_fr = 0; e_irl = 0; e_emr = 0; e_cm = 0; e_hlt = m_halt;
    if (!m_halt) begin
      e_stg = (m_phase == 4) ? 2'd0 : 2'(m_phase);
      e_fr  = (m_phase == 0) && bus.run_enable;
      e_irl = e_fr && bus.mem_ready;
      e_emr = (m_phase == 3) && bus.ex_needs_mem;
      e_cm  = (m_phase == 4) && !bus.error;
    end
  endfunction

  function automatic void model_advance();
    bit waiting, tmo;
    waiting = (e_fr || e_emr) && !bus.mem_ready;
    tmo     = waiting && (m_wait + 1 >= C_TO);
    if (e_cm) m_instret = m_instret + 32'd1;
    if (!m_halt) begin
      if (bus.error || tmo) begin
        m_halt = 1;
        if (tmo) m_to = 1;
      end else begin
        case (m_phase)
          0: if (bus.run_enable && bus.mem_ready) m_phase = 1;
          3: if (!bus.ex_needs_mem || bus.mem_ready) m_phase = 4;
          4: m_phase = 0;
          default: m_phase = m_phase + 1;
        endcase
      end
    end
    m_wait = (waiting && !tmo) ? m_wait + 1 : 0;
  endfunction

  // Called at a falling edge: apply inputs and let outputs settle.
  task automatic drive(input bit run, input bit rdy, input bit need, input bit err);
    bus.run_enable   = run;
    bus.mem_ready    = rdy;
    bus.ex_needs_mem = need;
    bus.error        = err;
    #1;
    model_outputs();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("stage",   64'(bus.current_pipeline_stage), 64'(e_stg));
    chk("fetch_req",  64'(bus.fetch_req),    64'(e_fr));
    chk("ir_load",    64'(bus.ir_load),      64'(e_irl));
    chk("ex_mem_req", 64'(bus.ex_mem_req),   64'(e_emr));
    chk("pc_write",   64'(bus.pc_write),     64'(e_cm));
    chk("reg_write_en", 64'(bus.reg_write_en), 64'(e_cm));
    chk("halted",     64'(bus.halted),       64'(e_hlt));
    chk("timeout_error", 64'(bus.timeout_error), 64'(m_to));
    chk("instret",    64'(bus.instret),      64'(m_instret));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.run_enable = 1'b1; bus.mem_ready = 1'b1;
    bus.ex_needs_mem = 1'b1; bus.error = 1'b0;
    #1;
    chk("rst_stage",   64'(bus.current_pipeline_stage), 64'd0);
    chk("rst_fetch_req", 64'(bus.fetch_req), 64'd0);
    chk("rst_halted",  64'(bus.halted), 64'd0);
    chk("rst_instret", 64'(bus.instret), 64'd0);
    chk("rst_timeout", 64'(bus.timeout_error), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Row: {run, rdy, need, err, stage[1:0], fetch_req, ir_load, ex_mem_req, pc_write, halted}
  typedef struct {
    bit run, rdy, need, err;
    bit [1:0] stg;
    bit fr, irl, emr, pcw, hlt;
  } vec_t;

  function automatic vec_t unpack(input logic [10:0] r);
    vec_t v;
    v.run = r[10]; v.rdy = r[9]; v.need = r[8]; v.err = r[7];
    v.stg = r[6:5];
    v.fr = r[4]; v.irl = r[3]; v.emr = r[2]; v.pcw = r[1]; v.hlt = r[0];
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = unpack(11'b1100_00_11000);  // ALU fetch
    tbl[1]  = unpack(11'b1100_01_00000);
    tbl[2]  = unpack(11'b1100_10_00000);
    tbl[3]  = unpack(11'b1100_11_00000);
    tbl[4]  = unpack(11'b1100_00_00010);  // writeback commit
    tbl[5]  = unpack(11'b0100_00_00000);  // idle fetch
    tbl[6]  = unpack(11'b1000_00_10000);  // fetch waiting
    tbl[7]  = unpack(11'b1100_00_11000);
    tbl[8]  = unpack(11'b1110_01_00000);
    tbl[9]  = unpack(11'b1110_10_00000);
    tbl[10] = unpack(11'b1010_11_00100);  // load waits 3 cycles
    tbl[11] = unpack(11'b1010_11_00100);
    tbl[12] = unpack(11'b1010_11_00100);
    tbl[13] = unpack(11'b1110_11_00100);  // ready on limit cycle wins
    tbl[14] = unpack(11'b1100_00_00010);
    tbl[15] = unpack(11'b1100_00_11000);
    tbl[16] = unpack(11'b1100_01_00000);
    tbl[17] = unpack(11'b1100_10_00000);
    tbl[18] = unpack(11'b1101_11_00000);  // error in first execute cycle
    tbl[19] = unpack(11'b1100_00_00001);
    tbl[20] = unpack(11'b1110_00_00001);

    do_reset();

    // Table-driven vectors.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].run, tbl[i].rdy, tbl[i].need, tbl[i].err);
      chk($sformatf("tbl%0d_stage", i), 64'(bus.current_pipeline_stage), 64'(tbl[i].stg));
      chk($sformatf("tbl%0d_fetch_req", i), 64'(bus.fetch_req), 64'(tbl[i].fr));
      chk($sformatf("tbl%0d_ir_load", i), 64'(bus.ir_load), 64'(tbl[i].irl));
      chk($sformatf("tbl%0d_ex_mem_req", i), 64'(bus.ex_mem_req), 64'(tbl[i].emr));
      chk($sformatf("tbl%0d_pc_write", i), 64'(bus.pc_write), 64'(tbl[i].pcw));
      chk($sformatf("tbl%0d_reg_write_en", i), 64'(bus.reg_write_en), 64'(tbl[i].pcw));
      chk($sformatf("tbl%0d_halted", i), 64'(bus.halted), 64'(tbl[i].hlt));
      tick();
    end
    // Halt is absorbing even with mem_ready held.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("halt_hold", 64'(bus.halted), 64'd1);
      chk("halt_no_fetch", 64'(bus.fetch_req), 64'd0);
      tick();
    end
    chk("halt_instret", 64'(bus.instret), 64'd2);

    // 50 back-to-back instructions-worth of cycles.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check_model();
      tick();
    end
    chk("run50_instret", 64'(bus.instret), 64'd10);

    // Execute fault reported in writeback.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("wberr_stage", 64'(bus.current_pipeline_stage), 64'd0);
    chk("wberr_pc_write", 64'(bus.pc_write), 64'd0);
    chk("wberr_reg_write_en", 64'(bus.reg_write_en), 64'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("wberr_halted", 64'(bus.halted), 64'd1);
    chk("wberr_instret", 64'(bus.instret), 64'd0);
    tick();

    // Fetch timeout.
    do_reset();
    for (int i = 0; i < C_TO; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("to_ir_load", 64'(bus.ir_load), 64'd0);
      chk("to_flag_early", 64'(bus.timeout_error), 64'd0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("to_halted", 64'(bus.halted), 64'd1);
    chk("to_flag", 64'(bus.timeout_error), 64'd1);
    chk("to_no_ir_load", 64'(bus.ir_load), 64'd0);
    tick();

    // mem_ready on the limit cycle completes the fetch.
    do_reset();
    for (int i = 0; i < C_TO - 1; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("edge_ir_load", 64'(bus.ir_load), 64'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("edge_stage", 64'(bus.current_pipeline_stage), 64'd1);
    chk("edge_no_timeout", 64'(bus.timeout_error), 64'd0);
    chk("edge_not_halted", 64'(bus.halted), 64'd0);
    tick();

    // Asynchronous reset during a waiting load.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("mid_ex_mem_req", 64'(bus.ex_mem_req), 64'd1);
    chk("mid_instret", 64'(bus.instret), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ex_mem_req", 64'(bus.ex_mem_req), 64'd0);
    chk("arst_halted", 64'(bus.halted), 64'd0);
    chk("arst_instret", 64'(bus.instret), 64'd0);
    chk("arst_fetch_req", 64'(bus.fetch_req), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_fetch_req1", 64'(bus.fetch_req), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_fetch_req0", 64'(bus.fetch_req), 64'd0);
    tick();

    // Randomized run against the reference model.
    begin
      int halt_cycles;
      halt_cycles = 0;
      for (int i = 0; i < 1500; i++) begin
        if (m_halt) halt_cycles++;
        else        halt_cycles = 0;
        if (halt_cycles > 6) begin
          do_reset();
          halt_cycles = 0;
        end
        drive(($urandom % 4) != 0, ($urandom % 3) != 0,
              ($urandom % 2) != 0, ($urandom % 80) == 0);
        check_model();
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
